// File: rtl/sad_search_sequencer.sv
// Full-search block-match sequencer: walks the window over the frame in raster order,
// issues one row request per window row, and keeps the minimum-SAD candidate.
module sad_search_sequencer #(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int WIN     = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        RowReq,
    input  logic        RowAck,
    output logic [31:0] Base,
    output logic [31:0] Row,
    input  logic        RowSadValid,
    input  logic [31:0] RowSad,
    output logic [31:0] BestSad,
    output logic [31:0] BestX,
    output logic [31:0] BestY
);

    localparam logic [31:0] XLAST   = 32'(FRAME_W - WIN);
    localparam logic [31:0] YLAST   = 32'(FRAME_H - WIN);
    localparam logic [31:0] ROWLAST = 32'(WIN - 1);
    localparam logic [31:0] FRAMEW  = 32'(FRAME_W);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic        last_row;
    logic        more_cands;

    assign acc_sum    = {1'b0, acc} + {1'b0, RowSad};
    assign last_row   = (Row == ROWLAST);
    assign more_cands = (x < XLAST) || (y < YLAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = ISSUE;
            ISSUE:   if (RowAck) next_state = WAIT;
            WAIT:    if (RowSadValid) next_state = last_row ? CMP : ISSUE;
            CMP:     next_state = more_cands ? ISSUE : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        Busy   = (state != IDLE);
        RowReq = (state == ISSUE);
        Done   = (state == DONE);
    end

    // Base follows x/y directly so it is already valid in the ISSUE cycle after CMP.
    assign Base = y * FRAMEW + x;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x       <= '0;
            y       <= '0;
            Row     <= '0;
            acc     <= '0;
            BestSad <= '1;
            BestX   <= '0;
            BestY   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        x       <= '0;
                        y       <= '0;
                        Row     <= '0;
                        acc     <= '0;
                        BestSad <= '1;
                        BestX   <= '0;
                        BestY   <= '0;
                    end
                end
                WAIT: begin
                    if (RowSadValid) begin
                        acc <= acc_sum[32] ? '1 : acc_sum[31:0];
                        if (!last_row) begin
                            Row <= Row + 32'd1;
                        end
                    end
                end
                CMP: begin
                    // Strict compare: an equal later candidate never displaces the earlier one.
                    if (acc < BestSad) begin
                        BestSad <= acc;
                        BestX   <= x;
                        BestY   <= y;
                    end
                    acc <= '0;
                    Row <= '0;
                    if (x < XLAST) begin
                        x <= x + 32'd1;
                    end else if (y < YLAST) begin
                        x <= '0;
                        y <= y + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
